// File: rtl/microcore_pkg.sv
// Shared constants and types for the microcore fetch path.
// Includes the instruction field layout, the opcode map and the fetch FSM encoding.
package microcore_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;

    localparam int OPC_LSB = 4;
    localparam int OPC_W   = 4;
    localparam int OPR_LSB = 0;
    localparam int OPR_W   = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_JMP = 4'h6,
        OP_JZ  = 4'h7,
        OP_OUT = 4'h8,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic {
        FS_PRIME = 1'b0,
        FS_RUN   = 1'b1
    } fetch_state_t;

    function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_LSB +: OPC_W];
    endfunction

    function automatic logic [OPR_W-1:0] instr_operand(input logic [INSTR_W-1:0] instr);
        return instr[OPR_LSB +: OPR_W];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous first-word-fall-through FIFO holding fetched {pc, instruction} entries.
// clr empties the queue and takes priority over a same-edge push or pop.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         head_vld,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wr <= ptr_next(r_wr);
            if (pop)  r_rd <= ptr_next(r_rd);
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never reset; emptiness is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (push && !clr) r_mem[r_wr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr) assert (!(push && !pop && (r_count == FULL_CNT)));
    end

    assign head     = r_mem[r_rd];
    assign head_vld = (r_count != '0);
    assign count    = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage between program_counter and the decoder: credit-limited PC advance,
// two-edge synchronous ROM read pipe with epoch tagging, FWFT buffer to the decoder.
module instruction_fetch #(
    parameter int ADDR_W  = microcore_pkg::ADDR_W,
    parameter int INSTR_W = microcore_pkg::INSTR_W,
    parameter int DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_W-1:0]               pc_value,
    input  logic                            pc_ack,
    output logic                            pc_en,
    output logic                            rom_en,
    output logic [ADDR_W-1:0]               rom_addr,
    input  logic [INSTR_W-1:0]              rom_data,
    input  logic                            flush,
    output logic                            ir_valid,
    input  logic                            ir_ready,
    output logic [microcore_pkg::OPC_W-1:0] ir_opcode,
    output logic [microcore_pkg::OPR_W-1:0] ir_operand,
    output logic [ADDR_W-1:0]               ir_pc,
    output logic                            fetch_err
);
    import microcore_pkg::OPC_LSB;
    import microcore_pkg::OPC_W;
    import microcore_pkg::OPR_LSB;
    import microcore_pkg::OPR_W;
    import microcore_pkg::fetch_state_t;
    import microcore_pkg::FS_PRIME;
    import microcore_pkg::FS_RUN;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + INSTR_W;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(DEPTH);

    fetch_state_t      r_state;
    logic [CNT_W-1:0]  r_outstanding;
    logic              r_epoch;
    logic              r_granted;

    logic              r_vld_p0;
    logic              r_live_p0;
    logic              r_ep_p0;
    logic [ADDR_W-1:0] r_pc_p0;
    logic              r_vld_p1;
    logic              r_live_p1;
    logic              r_ep_p1;
    logic [ADDR_W-1:0] r_pc_p1;

    logic              w_prime;
    logic              w_issue;
    logic              w_err;
    logic              w_push;
    logic              w_pop;
    logic              w_head_vld;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_used;
    logic [ENT_W-1:0]  w_head;

    // Every word is charged a credit from grant (or priming read) until its response lands.
    assign w_prime = (r_state == FS_PRIME);
    assign w_used  = {1'b0, w_count} + {1'b0, r_outstanding};
    assign pc_en   = !w_prime && !flush && (w_used < CREDIT_LIMIT);
    assign w_issue = w_prime || (pc_ack && r_granted);
    assign w_err   = !w_prime && pc_ack && !r_granted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FS_PRIME;
            r_outstanding <= '0;
            r_epoch       <= 1'b0;
            r_granted     <= 1'b0;
            r_vld_p0      <= 1'b0;
            r_live_p0     <= 1'b0;
            r_vld_p1      <= 1'b0;
            r_live_p1     <= 1'b0;
            rom_en        <= 1'b0;
            rom_addr      <= '0;
            fetch_err     <= 1'b0;
        end else begin
            r_state       <= FS_RUN;
            r_granted     <= pc_en;
            r_outstanding <= r_outstanding + CNT_W'(w_prime || pc_en) - CNT_W'(r_vld_p1);
            r_epoch       <= r_epoch ^ flush;
            rom_en        <= w_issue;
            if (w_issue) rom_addr <= pc_value;
            if (w_err)   fetch_err <= 1'b1;
            // p0: ROM samples the read; live is cleared for anything issued on a flush edge
            r_vld_p0      <= w_issue;
            r_live_p0     <= !flush;
            // p1: ROM data becomes valid; a flush here also kills the word
            r_vld_p1      <= r_vld_p0;
            r_live_p1     <= r_live_p0 && !flush;
        end
    end

    always_ff @(posedge clk) begin
        r_ep_p0 <= r_epoch;
        r_pc_p0 <= pc_value;
        r_ep_p1 <= r_ep_p0;
        r_pc_p1 <= r_pc_p0;
    end

    // Capture: response of a stale epoch still returns its credit but is never queued.
    assign w_push = r_vld_p1 && r_live_p1 && (r_ep_p1 == r_epoch) && !flush;
    assign w_pop  = w_head_vld && ir_ready && !flush;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (w_push),
        .push_data ({r_pc_p1, rom_data}),
        .pop       (w_pop),
        .head      (w_head),
        .head_vld  (w_head_vld),
        .count     (w_count)
    );

    assign ir_valid   = w_head_vld;
    assign ir_pc      = w_head_vld ? w_head[INSTR_W +: ADDR_W] : '0;
    assign ir_opcode  = w_head_vld ? w_head[OPC_LSB +: OPC_W] : '0;
    assign ir_operand = w_head_vld ? w_head[OPR_LSB +: OPR_W] : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch with a program_counter model and a sync ROM (mem[a] = a ^ A5).
// Expected instruction stream is a queue of consecutive addresses restarted at reset/flush.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc_m;
    logic       ack_m;
    logic       force_ack;
    logic       pc_ack;
    logic       pc_en;
    logic       rom_en;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       flush;
    logic       ir_valid;
    logic       ir_ready;
    logic [3:0] ir_opcode;
    logic [3:0] ir_operand;
    logic [7:0] ir_pc;
    logic       fetch_err;

    int tests    = 0;
    int fails    = 0;
    int accepted = 0;
    logic [15:0] exp_q[$];

    instruction_fetch #(.ADDR_W(8), .INSTR_W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_value   (pc_m),
        .pc_ack     (pc_ack),
        .pc_en      (pc_en),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .flush      (flush),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .ir_opcode  (ir_opcode),
        .ir_operand (ir_operand),
        .ir_pc      (ir_pc),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    // program_counter: advance on en, acknowledge one cycle later
    always @(posedge clk) begin
        if (rst) begin
            pc_m  <= 8'd0;
            ack_m <= 1'b0;
        end else begin
            ack_m <= pc_en;
            if (pc_en) pc_m <= pc_m + 8'd1;
        end
    end
    assign pc_ack = ack_m | force_ack;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_addr ^ 8'hA5;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic restart_expect(input logic [7:0] start);
        logic [7:0] a;
        exp_q.delete();
        a = start;
        for (int i = 0; i < 700; i++) begin
            exp_q.push_back({a, a ^ 8'hA5});
            a = a + 8'd1;
        end
    endtask

    // Monitor: every handshake pops the next expected {pc, opcode, operand}
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst && ir_valid && ir_ready) begin
                tests++;
                accepted++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_empty: got pc 0x%0h, expected no instruction", ir_pc);
                end else begin
                    e = exp_q.pop_front();
                    if ({ir_pc, ir_opcode, ir_operand} !== e) begin
                        fails++;
                        $display("FAIL sb_instr: got pc 0x%0h instr 0x%0h, expected pc 0x%0h instr 0x%0h",
                                 ir_pc, {ir_opcode, ir_operand}, e[15:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic wait_accepts(input string name, input int n, input int budget, input bit rnd);
        int target;
        target = accepted + n;
        for (int c = 0; c < budget && accepted < target; c++) begin
            @(posedge clk);
            #1;
            if (rnd) ir_ready = ($urandom_range(0, 3) != 0);
        end
        tests++;
        if (accepted < target) begin
            fails++;
            $display("FAIL %s_timeout: got %0d accepts, expected %0d", name, accepted, target);
        end
        ir_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pc_en"},      32'(pc_en),      32'd0);
        chk({tag, "_rom_en"},     32'(rom_en),     32'd0);
        chk({tag, "_rom_addr"},   32'(rom_addr),   32'd0);
        chk({tag, "_ir_valid"},   32'(ir_valid),   32'd0);
        chk({tag, "_ir_opcode"},  32'(ir_opcode),  32'd0);
        chk({tag, "_ir_operand"}, 32'(ir_operand), 32'd0);
        chk({tag, "_ir_pc"},      32'(ir_pc),      32'd0);
        chk({tag, "_fetch_err"},  32'(fetch_err),  32'd0);
    endtask

    task automatic release_and_check_start(input string tag);
        restart_expect(8'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_e0_rom_en"},   32'(rom_en),   32'd1);
        chk({tag, "_e0_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_e0_ir_valid"}, 32'(ir_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, "_e2_ir_valid"}, 32'(ir_valid), 32'd1);
        chk({tag, "_e2_ir_pc"},    32'(ir_pc),    32'd0);
        chk({tag, "_e2_opcode"},   32'(ir_opcode), 32'hA);
        chk({tag, "_e2_operand"},  32'(ir_operand), 32'h5);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] pc_hold;
        rst       = 1'b1;
        flush     = 1'b0;
        force_ack = 1'b0;
        ir_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        // 1: reset release, in-order stream
        release_and_check_start("start");
        wait_accepts("stream", 20, 200, 1'b0);

        // 2: decoder stall fills the buffer and stops the PC
        ir_ready = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        pc_hold = pc_m;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_pc_en",    32'(pc_en),             32'd0);
        chk("stall_ir_valid", 32'(ir_valid),          32'd1);
        chk("stall_count",    32'(dut.w_count),       32'd4);
        chk("stall_outstand", 32'(dut.r_outstanding), 32'd0);
        chk("stall_pc_held",  32'(pc_m),              32'(pc_hold));
        ir_ready = 1'b1;
        wait_accepts("stall_release", 30, 300, 1'b0);

        // 3: flushes at random points of random-ready traffic
        for (int k = 0; k < 4; k++) begin
            wait_accepts("pre_flush", $urandom_range(3, 20), 400, 1'b1);
            flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            chk("flush_ir_valid", 32'(ir_valid), 32'd0);
            restart_expect(pc_m + 8'd1);
            wait_accepts("post_flush", 12, 300, 1'b1);
        end

        // 5: spurious pc_ack while no increment is granted
        ir_ready = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("err_before", 32'(fetch_err), 32'd0);
        force_ack = 1'b1;
        @(posedge clk);
        #1;
        force_ack = 1'b0;
        chk("err_set",      32'(fetch_err), 32'd1);
        chk("err_no_issue", 32'(rom_en),    32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_no_push", 32'(dut.w_count), 32'd4);
        chk("err_sticky",  32'(fetch_err),   32'd1);
        wait_accepts("after_err", 25, 400, 1'b1);
        chk("err_still", 32'(fetch_err), 32'd1);

        // 4: one-cycle reset mid-stream
        wait_accepts("pre_rst", $urandom_range(5, 15), 300, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        release_and_check_start("restart");

        // 6: long random run crossing the FF->00 address wrap
        wait_accepts("wrap", 300, 4000, 1'b1);
        chk("wrap_err_clear", 32'(fetch_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
